tff_count_ctrl: RTL and testbench
=================================

Name: tff_count_ctrl

Overview:
- Sequencing controller for an external bank of WIDTH T flip-flops, each sharing CLK and RESET.
- Reads the bank state Q_VEC and drives per-bit toggle enables T_VEC so the bank behaves as a modulo-(MOD_VAL+1) up/down counter.
- Supports start, pause, clear and one-shot modes.
- The counter value lives only in the flip-flop bank. This block holds FSM state, a latched mode bit and a terminal-count flag.

Parameters:
WIDTH, 4, number of T flip-flops in the controlled bank

Ports:
CLK      input   1      rising-edge clock, shared with the T-FF bank
RESET    input   1      asynchronous, active-high reset, shared with the T-FF bank
START    input   1      level, sampled each edge: begin or resume counting
STOP     input   1      level: pause counting
CLR      input   1      level: drive bank to zero
DIR      input   1      1 = count up, 0 = count down; sampled live every cycle
ONESHOT  input   1      latched when START is accepted: stop after first wrap
MOD_VAL  input   WIDTH  terminal value; live every cycle
Q_VEC    input   WIDTH  current Q outputs of the T-FF bank
T_VEC    output  WIDTH  toggle enables to the bank's T inputs (combinational)
BUSY     output  1      high in RUN
TC       output  1      registered one-cycle terminal-count pulse
DONE     output  1      high in DONE

Behaviour:
Reset
- RESET=1 forces the FSM to IDLE immediately, independent of CLK. It also clears the oneshot latch and TC.
- While RESET=1: T_VEC=0, BUSY=0, TC=0, DONE=0. The bank reads 0 through the same reset.
- Reset asserted mid-RUN aborts the count with no further toggles. After release the FSM waits in IDLE for START.

States
- IDLE, RUN, PAUSE, DONE, CLEAR (3-bit encoding, free choice).

Transition priority, evaluated at each rising edge
- CLR > STOP > START.
- CLR=1 in any state -> CLEAR.
- CLEAR -> IDLE unconditionally after exactly one cycle.
- IDLE: START -> RUN, latching ONESHOT.
- RUN: STOP -> PAUSE. One-shot wrap -> DONE. Otherwise remain in RUN.
- PAUSE: START (with STOP=0) -> RUN. The ONESHOT latch is not re-sampled.
- DONE: START -> RUN, re-latching ONESHOT.
- START held high with STOP=1 does nothing.

Next-value function, used only in RUN
- Up, Q_VEC < MOD_VAL: next = Q_VEC + 1.
- Up, Q_VEC >= MOD_VAL: next = 0 (wrap).
- Down, Q_VEC = 0 or Q_VEC > MOD_VAL: next = MOD_VAL (wrap).
- Down, otherwise: next = Q_VEC - 1.
- Arithmetic is unsigned WIDTH-bit with no carry-out.
- MOD_VAL=0: next is always 0 and every RUN cycle is a wrap.

T_VEC
- RUN: Q_VEC XOR next.
- CLEAR: Q_VEC (toggles every set bit to 0).
- All other states: 0.
- Combinational from state, Q_VEC, DIR and MOD_VAL. The bank applies it at the following edge.

Latency
- START sampled at edge k: RUN is entered at k and the first count toggle lands at edge k+1.
- STOP sampled at edge k: no toggle at k+1.
- The edge that leaves RUN still applies the T_VEC computed in RUN. This holds for STOP, one-shot wrap and CLR.

TC
- Set to 1 for exactly the cycle after any edge at which a wrap toggle was applied while in RUN.
- Otherwise 0.
- Back-to-back wraps (MOD_VAL=0) keep TC high continuously.

DONE
- Entered on the same edge as the one-shot wrap, so the bank then holds 0 (up) or MOD_VAL (down).
- Holds with T_VEC=0 until START or CLR.

CLR in RUN
- The final RUN toggle is applied at the transition edge.
- CLEAR then zeros the bank one edge later.

Test Plan:
1. WIDTH=4, MOD_VAL=5, DIR=1, START pulse, ONESHOT=0 -> Q_VEC: 1,2,3,4,5,0,1…; TC high one cycle after Q returns to 0; BUSY=1 throughout.
2. MOD_VAL=5, DIR=0, starting from Q=0 -> Q_VEC: 5,4,3,2,1,0,5; TC after each wrap to 5.
3. ONESHOT=1, MOD_VAL=3, DIR=1 -> Q: 1,2,3,0, then DONE=1, BUSY=0, T_VEC=0, Q stays 0; a new START restarts counting at 1.
4. RUN at Q=6 with MOD_VAL=9: STOP for 3 cycles -> Q frozen at 7 (the in-flight toggle lands), PAUSE, T_VEC=0; START -> continues 8,9,0.
5. Q=11 (4'b1011) in RUN, assert CLR for 1 cycle -> one more toggle (Q=12), CLEAR cycle with T_VEC=4'b1100, Q=0, then IDLE; CLR together with START and STOP still goes to CLEAR.
6. Edge cases:
   - MOD_VAL=0 in RUN -> Q stays 0, TC continuously 1.
   - MOD_VAL lowered to 2 while Q=7, up -> next Q=0 with TC.
   - RESET asserted mid-cycle in RUN -> all outputs 0 before the next edge; Q=0.

Source files
------------

// File: rtl/tff_count_ctrl_if.sv
// rtl/tff_count_ctrl_if.sv - command, bank-state and status bundle for the T-FF count controller
interface tff_count_ctrl_if #(
  parameter int WIDTH = 4
);
  logic             start;
  logic             stop;
  logic             clr;
  logic             dir;
  logic             oneshot;
  logic [WIDTH-1:0] mod_val;
  logic [WIDTH-1:0] q_vec;
  logic [WIDTH-1:0] t_vec;
  logic             busy;
  logic             tc;
  logic             done;

  modport master (
    output start, stop, clr, dir, oneshot, mod_val, q_vec,
    input  t_vec, busy, tc, done
  );

  modport slave (
    input  start, stop, clr, dir, oneshot, mod_val, q_vec,
    output t_vec, busy, tc, done
  );
endinterface

// File: rtl/tff_count_ctrl.sv
// rtl/tff_count_ctrl.sv - sequences an external T-FF bank as a modulo-(mod_val+1) up/down counter
module tff_count_ctrl #(
  parameter int WIDTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  tff_count_ctrl_if.slave   bus
);
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RUN   = 3'd1,
    S_PAUSE = 3'd2,
    S_DONE  = 3'd3,
    S_CLEAR = 3'd4
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic             oneshot_q;
  logic             oneshot_nxt;
  logic             tc_q;
  logic [WIDTH-1:0] q_next;
  logic             wrap;
  logic             go;

  // start is ignored whenever stop is also asserted
  assign go = bus.start & ~bus.stop;

  always_comb begin
    q_next = '0;
    wrap   = 1'b0;
    if (bus.dir) begin
      if (bus.q_vec >= bus.mod_val) begin
        wrap   = 1'b1;
        q_next = '0;
      end else begin
        q_next = bus.q_vec + WIDTH'(1);
      end
    end else begin
      if (bus.q_vec == '0 || bus.q_vec > bus.mod_val) begin
        wrap   = 1'b1;
        q_next = bus.mod_val;
      end else begin
        q_next = bus.q_vec - WIDTH'(1);
      end
    end
  end

  always_comb begin
    state_nxt   = state;
    oneshot_nxt = oneshot_q;
    bus.t_vec   = '0;
    bus.busy    = 1'b0;
    bus.done    = 1'b0;
    case (state)
      S_IDLE: begin
        if (go) begin
          state_nxt   = S_RUN;
          oneshot_nxt = bus.oneshot;
        end
      end
      S_RUN: begin
        bus.busy  = 1'b1;
        bus.t_vec = bus.q_vec ^ q_next;
        if (bus.stop) begin
          state_nxt = S_PAUSE;
        end else if (oneshot_q && wrap) begin
          state_nxt = S_DONE;
        end
      end
      S_PAUSE: begin
        if (go) begin
          state_nxt = S_RUN;
        end
      end
      S_DONE: begin
        bus.done = 1'b1;
        if (go) begin
          state_nxt   = S_RUN;
          oneshot_nxt = bus.oneshot;
        end
      end
      S_CLEAR: begin
        bus.t_vec = bus.q_vec;
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
    // clear overrides every other request, including a same-edge start
    if (bus.clr) begin
      state_nxt   = S_CLEAR;
      oneshot_nxt = oneshot_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      oneshot_q <= 1'b0;
      tc_q      <= 1'b0;
    end else begin
      state     <= state_nxt;
      oneshot_q <= oneshot_nxt;
      tc_q      <= (state == S_RUN) && wrap;
    end
  end

  assign bus.tc = tc_q;
endmodule

// File: tb/tb_tff_count_ctrl.sv
// tb/tb_tff_count_ctrl.sv - directed bench with a behavioural T-FF bank around tff_count_ctrl
module tb_tff_count_ctrl;
  localparam int WIDTH = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic [WIDTH-1:0] bank_q;
  int               n_checks = 0;
  int               n_fail   = 0;

  tff_count_ctrl_if #(.WIDTH(WIDTH)) ifc ();

  tff_count_ctrl #(.WIDTH(WIDTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc.slave)
  );

  always #5 clk = ~clk;

  // external T flip-flop bank sharing clock and reset
  always @(posedge clk or posedge rst) begin
    if (rst) bank_q <= '0;
    else     bank_q <= bank_q ^ ifc.t_vec;
  end
  assign ifc.q_vec = bank_q;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_clear();
    ifc.clr = 1'b1;
    step();
    ifc.clr = 1'b0;
    step();
  endtask

  task automatic start_run();
    ifc.start = 1'b1;
    step();
    ifc.start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    ifc.start = 1'b0; ifc.stop = 1'b0; ifc.clr = 1'b0;
    ifc.dir = 1'b1; ifc.oneshot = 1'b0; ifc.mod_val = 4'd5;
    step();
    step();
    n_checks++;
    if (ifc.t_vec !== 4'd0 || ifc.busy !== 1'b0 || ifc.tc !== 1'b0 || ifc.done !== 1'b0 || ifc.q_vec !== 4'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: t_vec=%b busy=%b tc=%b done=%b q=%0d expected all zero",
               ifc.t_vec, ifc.busy, ifc.tc, ifc.done, ifc.q_vec);
    end
    rst = 1'b0;
    step();
    n_checks++;
    if (ifc.busy !== 1'b0 || ifc.q_vec !== 4'd0 || ifc.t_vec !== 4'd0) begin
      n_fail++;
      $display("FAIL idle_after_reset: busy=%b q=%0d t_vec=%b expected busy=0 q=0 t_vec=0",
               ifc.busy, ifc.q_vec, ifc.t_vec);
    end
  endtask

  task automatic test_count_up();
    logic [3:0] exp_q  [7] = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd0, 4'd1};
    logic       exp_tc [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    ifc.mod_val = 4'd5; ifc.dir = 1'b1; ifc.oneshot = 1'b0;
    start_run();
    n_checks++;
    if (ifc.busy !== 1'b1 || ifc.q_vec !== 4'd0) begin
      n_fail++;
      $display("FAIL up_enter_run: busy=%b q=%0d expected busy=1 q=0", ifc.busy, ifc.q_vec);
    end
    for (int i = 0; i < 7; i++) begin
      step();
      n_checks++;
      if (ifc.q_vec !== exp_q[i] || ifc.tc !== exp_tc[i] || ifc.busy !== 1'b1) begin
        n_fail++;
        $display("FAIL up_count[%0d]: q=%0d tc=%b busy=%b expected q=%0d tc=%b busy=1",
                 i, ifc.q_vec, ifc.tc, ifc.busy, exp_q[i], exp_tc[i]);
      end
    end
  endtask

  task automatic test_count_down();
    logic [3:0] exp_q  [7] = '{4'd5, 4'd4, 4'd3, 4'd2, 4'd1, 4'd0, 4'd5};
    logic       exp_tc [7] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    do_clear();
    n_checks++;
    if (ifc.q_vec !== 4'd0 || ifc.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL clear_to_idle: q=%0d busy=%b expected q=0 busy=0", ifc.q_vec, ifc.busy);
    end
    ifc.mod_val = 4'd5; ifc.dir = 1'b0;
    start_run();
    for (int i = 0; i < 7; i++) begin
      step();
      n_checks++;
      if (ifc.q_vec !== exp_q[i] || ifc.tc !== exp_tc[i]) begin
        n_fail++;
        $display("FAIL down_count[%0d]: q=%0d tc=%b expected q=%0d tc=%b",
                 i, ifc.q_vec, ifc.tc, exp_q[i], exp_tc[i]);
      end
    end
  endtask

  task automatic test_oneshot();
    do_clear();
    ifc.mod_val = 4'd3; ifc.dir = 1'b1; ifc.oneshot = 1'b1;
    start_run();
    ifc.oneshot = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      step();
      n_checks++;
      if (ifc.q_vec !== 4'(i) || ifc.busy !== 1'b1) begin
        n_fail++;
        $display("FAIL oneshot_count[%0d]: q=%0d busy=%b expected q=%0d busy=1", i, ifc.q_vec, ifc.busy, i);
      end
    end
    step();
    n_checks++;
    if (ifc.q_vec !== 4'd0 || ifc.done !== 1'b1 || ifc.busy !== 1'b0 || ifc.t_vec !== 4'd0 || ifc.tc !== 1'b1) begin
      n_fail++;
      $display("FAIL oneshot_done: q=%0d done=%b busy=%b t_vec=%b tc=%b expected q=0 done=1 busy=0 t_vec=0 tc=1",
               ifc.q_vec, ifc.done, ifc.busy, ifc.t_vec, ifc.tc);
    end
    step();
    n_checks++;
    if (ifc.q_vec !== 4'd0 || ifc.done !== 1'b1 || ifc.tc !== 1'b0) begin
      n_fail++;
      $display("FAIL oneshot_hold: q=%0d done=%b tc=%b expected q=0 done=1 tc=0", ifc.q_vec, ifc.done, ifc.tc);
    end
    start_run();
    step();
    n_checks++;
    if (ifc.q_vec !== 4'd1 || ifc.busy !== 1'b1 || ifc.done !== 1'b0) begin
      n_fail++;
      $display("FAIL oneshot_restart: q=%0d busy=%b done=%b expected q=1 busy=1 done=0", ifc.q_vec, ifc.busy, ifc.done);
    end
  endtask

  task automatic test_pause();
    logic [3:0] exp_q  [3] = '{4'd8, 4'd9, 4'd0};
    logic       exp_tc [3] = '{1'b0, 1'b0, 1'b1};
    do_clear();
    ifc.mod_val = 4'd9; ifc.dir = 1'b1;
    start_run();
    for (int i = 0; i < 6; i++) step();
    n_checks++;
    if (ifc.q_vec !== 4'd6 || ifc.t_vec !== 4'b0001) begin
      n_fail++;
      $display("FAIL pause_setup: q=%0d t_vec=%b expected q=6 t_vec=0001", ifc.q_vec, ifc.t_vec);
    end
    ifc.stop = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      n_checks++;
      if (ifc.q_vec !== 4'd7 || ifc.busy !== 1'b0 || ifc.t_vec !== 4'd0) begin
        n_fail++;
        $display("FAIL pause_hold[%0d]: q=%0d busy=%b t_vec=%b expected q=7 busy=0 t_vec=0",
                 i, ifc.q_vec, ifc.busy, ifc.t_vec);
      end
    end
    ifc.start = 1'b1;
    step();
    n_checks++;
    if (ifc.busy !== 1'b0 || ifc.q_vec !== 4'd7) begin
      n_fail++;
      $display("FAIL pause_start_with_stop: busy=%b q=%0d expected busy=0 q=7", ifc.busy, ifc.q_vec);
    end
    ifc.stop = 1'b0;
    step();
    ifc.start = 1'b0;
    n_checks++;
    if (ifc.busy !== 1'b1 || ifc.q_vec !== 4'd7) begin
      n_fail++;
      $display("FAIL pause_resume: busy=%b q=%0d expected busy=1 q=7", ifc.busy, ifc.q_vec);
    end
    for (int i = 0; i < 3; i++) begin
      step();
      n_checks++;
      if (ifc.q_vec !== exp_q[i] || ifc.tc !== exp_tc[i]) begin
        n_fail++;
        $display("FAIL resume_count[%0d]: q=%0d tc=%b expected q=%0d tc=%b",
                 i, ifc.q_vec, ifc.tc, exp_q[i], exp_tc[i]);
      end
    end
  endtask

  task automatic test_clear_in_run();
    do_clear();
    ifc.mod_val = 4'd15; ifc.dir = 1'b1;
    start_run();
    for (int i = 0; i < 11; i++) step();
    n_checks++;
    if (ifc.q_vec !== 4'd11 || ifc.t_vec !== 4'b0111) begin
      n_fail++;
      $display("FAIL clr_setup: q=%0d t_vec=%b expected q=11 t_vec=0111", ifc.q_vec, ifc.t_vec);
    end
    ifc.clr = 1'b1; ifc.start = 1'b1; ifc.stop = 1'b1;
    step();
    ifc.clr = 1'b0; ifc.start = 1'b0; ifc.stop = 1'b0;
    n_checks++;
    if (ifc.q_vec !== 4'd12 || ifc.t_vec !== 4'b1100 || ifc.busy !== 1'b0 || ifc.done !== 1'b0) begin
      n_fail++;
      $display("FAIL clr_state: q=%0d t_vec=%b busy=%b done=%b expected q=12 t_vec=1100 busy=0 done=0",
               ifc.q_vec, ifc.t_vec, ifc.busy, ifc.done);
    end
    step();
    n_checks++;
    if (ifc.q_vec !== 4'd0 || ifc.t_vec !== 4'd0 || ifc.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL clr_zeroed: q=%0d t_vec=%b busy=%b expected q=0 t_vec=0 busy=0", ifc.q_vec, ifc.t_vec, ifc.busy);
    end
    ifc.start = 1'b1; ifc.stop = 1'b1;
    step();
    ifc.start = 1'b0; ifc.stop = 1'b0;
    n_checks++;
    if (ifc.busy !== 1'b0 || ifc.q_vec !== 4'd0) begin
      n_fail++;
      $display("FAIL idle_start_with_stop: busy=%b q=%0d expected busy=0 q=0", ifc.busy, ifc.q_vec);
    end
  endtask

  task automatic test_edge_cases();
    do_clear();
    ifc.mod_val = 4'd0; ifc.dir = 1'b1;
    start_run();
    for (int i = 0; i < 4; i++) begin
      step();
      n_checks++;
      if (ifc.q_vec !== 4'd0 || ifc.tc !== 1'b1 || ifc.busy !== 1'b1) begin
        n_fail++;
        $display("FAIL mod0[%0d]: q=%0d tc=%b busy=%b expected q=0 tc=1 busy=1", i, ifc.q_vec, ifc.tc, ifc.busy);
      end
    end
    ifc.mod_val = 4'd15;
    for (int i = 0; i < 7; i++) step();
    ifc.mod_val = 4'd2;
    #1;
    n_checks++;
    if (ifc.q_vec !== 4'd7 || ifc.t_vec !== 4'b0111) begin
      n_fail++;
      $display("FAIL mod_lowered_tvec: q=%0d t_vec=%b expected q=7 t_vec=0111", ifc.q_vec, ifc.t_vec);
    end
    step();
    n_checks++;
    if (ifc.q_vec !== 4'd0 || ifc.tc !== 1'b1) begin
      n_fail++;
      $display("FAIL mod_lowered_wrap: q=%0d tc=%b expected q=0 tc=1", ifc.q_vec, ifc.tc);
    end
    step();
    step();
    n_checks++;
    if (ifc.q_vec !== 4'd2 || ifc.tc !== 1'b0) begin
      n_fail++;
      $display("FAIL mod_lowered_count: q=%0d tc=%b expected q=2 tc=0", ifc.q_vec, ifc.tc);
    end
    #2;
    rst = 1'b1;
    #1;
    n_checks++;
    if (ifc.q_vec !== 4'd0 || ifc.t_vec !== 4'd0 || ifc.busy !== 1'b0 || ifc.tc !== 1'b0 || ifc.done !== 1'b0) begin
      n_fail++;
      $display("FAIL async_reset: q=%0d t_vec=%b busy=%b tc=%b done=%b expected all zero",
               ifc.q_vec, ifc.t_vec, ifc.busy, ifc.tc, ifc.done);
    end
    step();
    rst = 1'b0;
    step();
    n_checks++;
    if (ifc.q_vec !== 4'd0 || ifc.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_after_abort: q=%0d busy=%b expected q=0 busy=0", ifc.q_vec, ifc.busy);
    end
    ifc.mod_val = 4'd5;
    start_run();
    step();
    n_checks++;
    if (ifc.q_vec !== 4'd1 || ifc.busy !== 1'b1) begin
      n_fail++;
      $display("FAIL restart_after_reset: q=%0d busy=%b expected q=1 busy=1", ifc.q_vec, ifc.busy);
    end
  endtask

  initial begin
    test_reset();
    test_count_up();
    test_count_down();
    test_oneshot();
    test_pause();
    test_clear_in_run();
    test_edge_cases();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
